// File: rtl/db_qp_pkg.sv
// Shared defaults and clear-sequencer state encoding for the ping-pong deblocking QP store.
package db_qp_pkg;

    localparam int QP_WIDTH = 20;
    localparam int QP_DEPTH = 64;

    localparam logic CLR_IDLE = 1'b0;
    localparam logic CLR_RUN  = 1'b1;

    typedef enum logic {
        ST_IDLE = CLR_IDLE,
        ST_CLR  = CLR_RUN
    } clr_state_t;

endpackage

// File: rtl/db_qp_bank_sp.sv
// One single-port QP bank, low-active cen/wen, registered read data.
// Behavioural array (RTL_MODEL) by default; define DB_QP_MEM_MACRO to bind the compiled SRAM macro.
module db_qp_bank_sp #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 64,
    parameter int ADR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             cen,
    input  logic             wen,
    input  logic [ADR_W-1:0] adr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

`ifdef DB_QP_MEM_MACRO
    db_qp_sram_sp_macro #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_macro (
        .CLK (clk),
        .CEN (cen),
        .WEN (wen),
        .A   (adr),
        .D   (din),
        .Q   (dout)
    );
`else
    logic [WIDTH-1:0] mem [DEPTH];

    // dout only changes on a read access, so it holds between reads
    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[adr] <= din;
            end else begin
                dout <= mem[adr];
            end
        end
    end
`endif

endmodule

// File: rtl/db_qp_ram_pp.sv
// Ping-pong QP store: two single-port banks, done/ready bank swap, hardware clear sequencer.
// Define DB_QP_RAM_RD_REG_EN for an extra output register (read latency 2 instead of 1).
module db_qp_ram_pp
    import db_qp_pkg::*;
#(
    parameter int               WIDTH   = QP_WIDTH,
    parameter int               DEPTH   = QP_DEPTH,
    parameter int               ADR_W   = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [ADR_W-1:0] wr_adr_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             wr_done_i,
    output logic             wr_rdy_o,
    input  logic             rd_en_i,
    input  logic [ADR_W-1:0] rd_adr_i,
    input  logic             rd_done_i,
    output logic             rd_rdy_o,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             rd_vld_o,
    input  logic             clr_i,
    output logic             clr_busy_o
);

    clr_state_t       state_reg, state_next;
    logic [1:0]       full_reg, full_next;
    logic             wr_bank_reg, wr_bank_next;
    logic             rd_bank_reg, rd_bank_next;
    logic [ADR_W-1:0] clr_cnt_reg, clr_cnt_next;

    logic             clr_busy;
    logic             wr_rdy, rd_rdy;
    logic             wr_oor, rd_oor;
    logic             wr_fire, rd_fire;

    assign clr_busy = (state_reg == ST_CLR);
    assign wr_rdy   = !full_reg[wr_bank_reg] & !clr_busy;
    assign rd_rdy   = full_reg[rd_bank_reg] & !clr_busy;
    assign wr_oor   = 32'(wr_adr_i) >= DEPTH;
    assign rd_oor   = 32'(rd_adr_i) >= DEPTH;
    assign wr_fire  = wr_en_i & wr_rdy & !wr_oor;
    // out-of-range reads still complete, returning CLR_VAL without touching a bank
    assign rd_fire  = rd_en_i & rd_rdy;

    assign wr_rdy_o   = wr_rdy;
    assign rd_rdy_o   = rd_rdy;
    assign clr_busy_o = clr_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            full_reg    <= '0;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            full_reg    <= full_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        full_next    = full_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clr_i) begin
                    state_next   = ST_CLR;
                    full_next    = '0;
                    wr_bank_next = 1'b0;
                    rd_bank_next = 1'b0;
                    clr_cnt_next = '0;
                end else begin
                    // writer needs an empty bank, reader a full one, so these never collide
                    if (wr_done_i && wr_rdy) begin
                        full_next[wr_bank_reg] = 1'b1;
                        wr_bank_next           = !wr_bank_reg;
                    end
                    if (rd_done_i && rd_rdy) begin
                        full_next[rd_bank_reg] = 1'b0;
                        rd_bank_next           = !rd_bank_reg;
                    end
                end
            end
            ST_CLR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == ADR_W'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    logic [1:0]       bank_wr;
    logic [1:0]       bank_rd;
    logic [WIDTH-1:0] bank_dout [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [ADR_W-1:0] bank_adr;
            logic [WIDTH-1:0] bank_din;

            assign bank_wr[gi] = clr_busy | (wr_fire & (wr_bank_reg == 1'(gi)));
            assign bank_rd[gi] = rd_fire & !rd_oor & (rd_bank_reg == 1'(gi));
            assign bank_adr    = clr_busy ? clr_cnt_reg : (bank_wr[gi] ? wr_adr_i : rd_adr_i);
            assign bank_din    = clr_busy ? CLR_VAL : wr_dat_i;

            db_qp_bank_sp #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .ADR_W (ADR_W)
            ) u_bank (
                .clk  (clk),
                .cen  (!(bank_wr[gi] | bank_rd[gi])),
                .wen  (!bank_wr[gi]),
                .adr  (bank_adr),
                .din  (bank_din),
                .dout (bank_dout[gi])
            );
        end
    endgenerate

    logic             rd_vld_s1_reg;
    logic             rd_sel_reg;
    logic             rd_oor_reg;
    logic [WIDTH-1:0] rd_dat_reg;
    logic [WIDTH-1:0] rd_word;

    assign rd_word = rd_oor_reg ? CLR_VAL : bank_dout[rd_sel_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_s1_reg <= 1'b0;
            rd_sel_reg    <= 1'b0;
            rd_oor_reg    <= 1'b0;
            rd_dat_reg    <= '0;
        end else begin
            rd_vld_s1_reg <= rd_fire;
            if (rd_fire) begin
                rd_sel_reg <= rd_bank_reg;
                rd_oor_reg <= rd_oor;
            end
            if (rd_vld_s1_reg) begin
                rd_dat_reg <= rd_word;
            end
        end
    end

`ifdef DB_QP_RAM_RD_REG_EN
    logic rd_vld_s2_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_s2_reg <= 1'b0;
        end else begin
            rd_vld_s2_reg <= rd_vld_s1_reg;
        end
    end

    assign rd_vld_o = rd_vld_s2_reg;
    assign rd_dat_o = rd_dat_reg;
`else
    // rd_dat_reg remembers the last delivered word so the output holds between reads
    assign rd_vld_o = rd_vld_s1_reg;
    assign rd_dat_o = rd_vld_s1_reg ? rd_word : rd_dat_reg;
`endif

endmodule
